// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds FSM encodings, the default reset PC and the buffered fetch entry layout.
package fetch_ctrl_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // The RAM returns an aligned doubleword; pc[2] picks which half is the instruction.
    function automatic logic [INST_W-1:0] inst_select(input logic [63:0] dword, input logic hi);
        return hi ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction RAM handshake, jump redirect and decode valid/ready.
// master = fetch controller, slave = RAM/decode environment.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [63:0]       mem_rdata_i;
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              inst_valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              id_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, jump_flag_i, jump_addr_i, id_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, jump_flag_i, jump_addr_i, id_ready_i
    );

endinterface

// File: rtl/fetch_ctrl_inst_fifo.sv
// Synchronous FIFO of {pc, inst}; head is combinational, push/pop take effect at the edge.
// Clear wins over push/pop; push is refused when full unless a pop frees the slot.
module inst_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry_t  push_dat,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding RAM read at a time, results buffered for decode.
// First instruction 3 cycles after reset, one per 2 cycles sustained; stalls fetch while the buffer is full.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              mem_req;

    fetch_entry_t      push_dat;
    fetch_entry_t      head_dat;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              jump;
    logic              slot_after_push;

    assign jump = bus.jump_flag_i;
    assign pop  = !empty && bus.id_ready_i;
    assign push = (state == WAIT) && bus.mem_rvalid_i && !jump;

    assign push_dat.pc   = req_pc;
    assign push_dat.inst = inst_select(bus.mem_rdata_i, req_pc[2]);

    // WAIT never starts with a full buffer, so after the push a slot remains
    // if something pops now or the buffer held fewer than DEPTH-1 entries.
    assign slot_after_push = pop || (count < CW'(FIFO_DEPTH - 1));

    inst_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .clear    (jump),
        .push_dat (push_dat),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            req_pc  <= '0;
            mem_req <= 1'b0;
        end else begin
            if (jump) begin
                pc <= bus.jump_addr_i;
            end
            unique case (state)
                IDLE: begin
                    if (jump || !full) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt_i) begin
                        req_pc  <= pc;
                        state   <= jump ? DROP : WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        if (jump || slot_after_push) begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                        end else begin
                            state   <= IDLE;
                        end
                        if (!jump) begin
                            pc <= req_pc + 64'd4;
                        end
                    end else if (jump) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    // A jump here only retargets pc; the stale response still has to drain.
                    if (bus.mem_rvalid_i) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = {pc[ADDR_W-1:3], 3'b000};
    assign bus.inst_valid_o = !empty;
    assign bus.inst_o       = empty ? '0 : head_dat.inst;
    assign bus.inst_addr_o  = empty ? '0 : head_dat.pc;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch between the PC, the instruction RAM and the IF/ID register. It owns the fetch PC and issues one request at a time to a variable-latency RAM with a request/grant/response handshake. Fetched instructions go into a small FIFO that presents them to decode with valid/ready flow control. Jumps redirect the PC, flush the FIFO and discard any response still in flight.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, 2..8)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
mem_req_o  output  1  fetch request to instruction RAM
mem_addr_o  output  64  fetch address, 8-byte aligned (pc with [2:0] = 0)
mem_gnt_i  input  1  RAM accepted the request this cycle
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  64  read doubleword
jump_flag_i  input  1  redirect fetch
jump_addr_i  input  64  redirect target, 4-byte aligned
inst_valid_o  output  1  FIFO head valid
inst_o  output  32  instruction at FIFO head
inst_addr_o  output  64  PC of the FIFO head instruction
id_ready_i  input  1  decode accepts the head this cycle

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC, FIFO empty, state<=IDLE. Outputs mem_req_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0.
- Shared resource rule: at most one outstanding RAM transaction.
- States:
  - IDLE: mem_req_o=0. Go to REQ when the FIFO has a free slot (count<FIFO_DEPTH).
  - REQ: mem_req_o=1, mem_addr_o={pc[63:3],3'b0}. Hold the address stable until grant. On mem_gnt_i, latch req_pc<=pc and go to WAIT.
  - WAIT: mem_req_o=0. On mem_rvalid_i, push {req_pc, inst} and set pc<=req_pc+4. Next state is REQ if a slot stays free after the push (pops this cycle included), else IDLE.
  - DROP: mem_req_o=0. Wait for the in-flight response and discard it. Then go to REQ.
- Instruction select: inst = req_pc[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0]. PC arithmetic is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Request gating: a request is raised only when count<FIFO_DEPTH, so a response can always be pushed without overflow.
- Output: inst_valid_o = count!=0. inst_o and inst_addr_o come combinationally from the head entry and read 0 when empty. A pop happens when inst_valid_o and id_ready_i are both 1.
- Simultaneous push and pop: count is unchanged, and both take effect.
- Full FIFO: no request is issued. id_ready_i=0 holds the head stable indefinitely.
- Latency: with a grant in the same cycle and rvalid one cycle after grant, the first instruction is valid at the 3rd posedge after rst deasserts. Sustained rate is one instruction per 2 cycles.
- Jump (jump_flag_i=1) has priority over every other event in the same cycle:
  - pc<=jump_addr_i and the FIFO is cleared; a same-cycle pop or push is discarded.
  - From IDLE or REQ without grant: go to REQ. The new address appears the next cycle.
  - From REQ with mem_gnt_i=1 in the same cycle: go to DROP.
  - From WAIT without rvalid: go to DROP.
  - From WAIT with rvalid: drop the data and go to REQ.
  - From DROP: stay in DROP; only the pc is updated.
- Reset mid-transaction: the state returns to IDLE and the FIFO clears. Any RAM response arriving after reset in IDLE is ignored, because rvalid is only sampled in WAIT and DROP. The RAM must be reset with the core.
- mem_rvalid_i in IDLE or REQ is ignored.

Decomposition:
- Shared package/defines header holds:
  - state encodings: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DROP=2'd3
  - reset-PC constant
  - instruction-width and address-width constants
- One sub-module: inst_fifo. It is a parameterised synchronous FIFO of {pc[63:0], inst[31:0]} with push, pop, clear (clear wins), count, full and empty.
- Everything else stays in fetch_ctrl.

Test Plan:
- Reset, RAM grants immediately with rvalid 1 cycle later and rdata = {32'h00000013, 32'h00100093}, id_ready_i=1 -> first inst_o=32'h00100093 @ inst_addr_o=32'h8000_0000, second 32'h00000013 @ 0x8000_0004.
- id_ready_i=0 with RAM always responding -> exactly 2 entries captured, mem_req_o stays 0, head stable. Raise id_ready_i -> order 0x8000_0000, 0x8000_0004, 0x8000_0008 with no loss or duplicates.
- Grant delayed 3 cycles -> mem_addr_o held constant at 0x8000_0000 while mem_req_o=1.
- jump_flag_i with jump_addr_i=0x8000_0100 during WAIT, rvalid 2 cycles later -> old data discarded, FIFO empty, next mem_addr_o=0x8000_0100, next inst_addr_o=0x8000_0100.
- Jump on the same cycle as a pop and a push -> FIFO empty afterwards, pc=jump target, no stale instruction ever presented.
- pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next fetch address 0x0 with upper word selected first. Assert rst mid-WAIT -> outputs 0 next cycle, fetch resumes at RESET_PC.
